// File: rtl/mips_main_fsm.sv
// mips_main_fsm: multi-cycle main control FSM for the MIPS core.
// Steps fetch/decode/execute/memory/writeback and drives datapath mux selects.
module mips_main_fsm #(
    parameter int ALU_SRC_B_INPUTS = 4,
    parameter int PC_SRC_INPUTS    = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [5:0]                           opcode,
    input  logic                                 zero,
    output logic                                 iord,
    output logic                                 mem_write,
    output logic                                 ir_write,
    output logic                                 reg_dst,
    output logic                                 mem_to_reg,
    output logic                                 reg_write,
    output logic                                 alu_src_a,
    output logic [$clog2(ALU_SRC_B_INPUTS)-1:0]  alu_src_b,
    output logic [1:0]                           alu_op,
    output logic [$clog2(PC_SRC_INPUTS)-1:0]     pc_src,
    output logic                                 pc_en,
    output logic                                 illegal_op
);

    localparam int BW = $clog2(ALU_SRC_B_INPUTS);
    localparam int PW = $clog2(PC_SRC_INPUTS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     state;
    logic [5:0] op_q;
    logic       pc_write;
    logic       branch;

    // State register, DECODE-time opcode copy and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            op_q       <= 6'd0;
            illegal_op <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    unique case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default: begin
                            state      <= S_FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (op_q == OP_SW) state <= S_MEMWR;
                    else               state <= S_MEMRD;
                end
                S_MEMRD:   state <= S_MEMWB;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                S_MEMWB, S_MEMWR, S_ALUWB,
                S_BRANCH, S_ADDIWB, S_JUMP:
                           state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode: every control line is a function of state only
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = BW'(0);
        alu_op     = ALU_ADD;
        pc_src     = PW'(0);
        pc_write   = 1'b0;
        branch     = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = BW'(1);
            end
            S_DECODE: begin
                alu_src_b = BW'(3);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = BW'(2);
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                pc_src    = PW'(1);
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = BW'(2);
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PW'(2);
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    // Branch resolves from the live zero flag in the same cycle
    assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_main_fsm.sv
// tb_mips_main_fsm: random instruction stream checked against a per-phase
// model of the control outputs derived from the instruction class.
module tb_mips_main_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, pc_en, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;

    int total = 0;
    int bad   = 0;
    logic flag_m = 1'b0;

    typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL} cls_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] src_b;
        logic [1:0] op;
        logic [1:0] ps;
        logic       pc_en;
    } vec_t;

    mips_main_fsm #(.ALU_SRC_B_INPUTS(4), .PC_SRC_INPUTS(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int cycles(input cls_t c);
        case (c)
            C_LW:    return 5;
            C_SW, C_R, C_ADDI: return 4;
            C_BEQ, C_J: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs for phase k of an instruction of class c
    function automatic vec_t expect_vec(input cls_t c, input int k,
                                        input logic z);
        vec_t v = '0;
        if (k == 0) begin
            v.ir_write = 1; v.pc_en = 1; v.src_b = 2'd1;
        end else if (k == 1) begin
            v.src_b = 2'd3;
        end else begin
            case (c)
                C_LW: begin
                    if (k == 2) begin v.alu_src_a = 1; v.src_b = 2'd2; end
                    if (k == 3) v.iord = 1;
                    if (k == 4) begin v.reg_write = 1; v.mem_to_reg = 1; end
                end
                C_SW: begin
                    if (k == 2) begin v.alu_src_a = 1; v.src_b = 2'd2; end
                    if (k == 3) begin v.iord = 1; v.mem_write = 1; end
                end
                C_R: begin
                    if (k == 2) begin v.alu_src_a = 1; v.op = 2'b10; end
                    if (k == 3) begin v.reg_write = 1; v.reg_dst = 1; end
                end
                C_ADDI: begin
                    if (k == 2) begin v.alu_src_a = 1; v.src_b = 2'd2; end
                    if (k == 3) v.reg_write = 1;
                end
                C_BEQ: begin
                    v.alu_src_a = 1; v.op = 2'b01; v.ps = 2'd1; v.pc_en = z;
                end
                C_J: begin
                    v.ps = 2'd2; v.pc_en = 1;
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input vec_t e, input logic ef);
        vec_t o;
        o = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, pc_en};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, o, e);
        end
        total++;
        assert (illegal_op === ef) else begin
            bad++;
            $error("FAIL %s illegal_op observed=%b expected=%b",
                   tag, illegal_op, ef);
        end
    endtask

    // zmode: 0/1 forces zero, 2 randomizes; rst_at: phase to reset in, -1 none
    task automatic run_instr(input logic [5:0] op, input int zmode,
                             input int rst_at);
        cls_t c;
        int   n;
        c = classify(op);
        n = cycles(c);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            opcode = (k == 1) ? op : 6'($urandom);
            zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check($sformatf("op%02h_k%0d", op, k), expect_vec(c, k, zero),
                  flag_m);
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                flag_m = 1'b0;
                check("midrst", expect_vec(C_LW, 0, zero), flag_m);
                @(posedge clk);
                #2 rst = 1'b0;
                return;
            end
        end
        if (c == C_ILL) flag_m = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] t;
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0: t = 6'b100011;
            1: t = 6'b101011;
            2: t = 6'b000000;
            3: t = 6'b000100;
            4: t = 6'b001000;
            5: t = 6'b000010;
            default: begin
                t = 6'($urandom);
                while (classify(t) != C_ILL) t = 6'($urandom);
            end
        endcase
        return t;
    endfunction

    initial begin
        rst    = 1'b1;
        opcode = 6'd0;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("reset", expect_vec(C_LW, 0, zero), 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_instr(6'b100011, 2, -1);
        run_instr(6'b101011, 2, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b000000, 2, -1);
        run_instr(6'b000010, 2, -1);
        run_instr(6'b111111, 2, -1);
        run_instr(6'b100011, 2, -1);
        run_instr(6'b101011, 2, 3);
        run_instr(6'b001000, 2, -1);

        for (int i = 0; i < 120; i++) begin
            logic [5:0] op;
            int ra;
            op = rand_op();
            ra = ($urandom_range(0, 9) == 0) ?
                 $urandom_range(1, cycles(classify(op)) - 1) : -1;
            run_instr(op, 2, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
